project_pwm_channel: RTL and testbench

PROJECT_PWM_CHANNEL -- requirements
Module: project_pwm_channel

---
 rtl/project_pwm_channel_pkg.sv | 28 ++
 rtl/project_pwm_channel_deadtime_gen.sv | 100 ++++++++++
 rtl/project_pwm_channel.sv | 63 ++++++
 tb/tb_project_pwm_channel.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_pwm_channel_pkg.sv
// Shared definitions for the PWM channel: counter-mode encodings, dead-time
// FSM states and datapath widths.
package project_pwm_channel_pkg;

  localparam int CNT_W = 16;
  localparam int DT_W  = 8;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_UPDOWN = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_HI,
    ST_LO,
    ST_DT_TO_HI,
    ST_DT_TO_LO
  } dt_state_e;

  // A channel compares only while enabled and while the master counter runs.
  function automatic logic modeRunning(input logic [1:0] mode);
    return mode_e'(mode) != MODE_STOP;
  endfunction

endpackage

// File: rtl/project_pwm_channel_deadtime_gen.sv
// Dead-time generator: turns the raw compare bit into non-overlapping
// high-side/low-side drives with a programmable blanking interval.
module project_deadtime_gen
  import project_pwm_channel_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            en_i,
  input  logic            raw_i,
  input  logic [DT_W-1:0] deadtime_i,
  output logic            h_o,
  output logic            l_o
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_OFF;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A reversal of raw inside a dead band restarts the opposite dead band, so
  // both sides stay off and can never overlap.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!en_i) begin
      state_d = ST_OFF;
      count_d = '0;
    end else begin
      case (state_q)
        ST_OFF, ST_LO, ST_DT_TO_LO: begin
          if (raw_i) begin
            if (deadtime_i == '0) begin
              state_d = ST_HI;
              count_d = '0;
            end else begin
              state_d = ST_DT_TO_HI;
              count_d = deadtime_i;
            end
          end else if (state_q == ST_OFF) begin
            if (deadtime_i == '0) begin
              state_d = ST_LO;
              count_d = '0;
            end else begin
              state_d = ST_DT_TO_LO;
              count_d = deadtime_i;
            end
          end else if (state_q == ST_DT_TO_LO) begin
            if (count_q <= 8'd1) begin
              state_d = ST_LO;
              count_d = '0;
            end else begin
              count_d = count_q - 8'd1;
            end
          end
        end
        ST_HI, ST_DT_TO_HI: begin
          if (!raw_i) begin
            if (deadtime_i == '0) begin
              state_d = ST_LO;
              count_d = '0;
            end else begin
              state_d = ST_DT_TO_LO;
              count_d = deadtime_i;
            end
          end else if (state_q == ST_DT_TO_HI) begin
            if (count_q <= 8'd1) begin
              state_d = ST_HI;
              count_d = '0;
            end else begin
              count_d = count_q - 8'd1;
            end
          end
        end
        default: begin
          state_d = ST_OFF;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    h_o = 1'b0;
    l_o = 1'b0;
    case (state_q)
      ST_HI:   h_o = 1'b1;
      ST_LO:   l_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/project_pwm_channel.sv
// PWM channel slaved to a period counter master: shadowed duty/dead-time,
// registered compare stage, dead-time generator and output polarity.
module project_pwm_channel
  import project_pwm_channel_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_sync,
  input  logic [CNT_W-1:0] i_counter,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [DT_W-1:0]  i_deadtime,
  input  logic             i_polarity,
  output logic             o_pwm_h,
  output logic             o_pwm_l,
  output logic [CNT_W-1:0] o_duty_active
);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic [DT_W-1:0]  deadtime_q, deadtime_d;
  logic             raw_q, raw_d;
  logic             dtH, dtL;

  // Shadows track the requested values while disabled so a fresh enable
  // starts with current settings; while running they move only at sync.
  always_comb begin
    duty_d     = duty_q;
    deadtime_d = deadtime_q;
    if (i_sync || !i_en) begin
      duty_d     = i_duty;
      deadtime_d = i_deadtime;
    end
    raw_d = i_en && modeRunning(i_mode) && (i_counter < duty_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      duty_q     <= '0;
      deadtime_q <= '0;
      raw_q      <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      deadtime_q <= deadtime_d;
      raw_q      <= raw_d;
    end
  end

  project_deadtime_gen u_deadtime (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .en_i       (i_en),
    .raw_i      (raw_q),
    .deadtime_i (deadtime_q),
    .h_o        (dtH),
    .l_o        (dtL)
  );

  assign o_pwm_h       = dtH ^ i_polarity;
  assign o_pwm_l       = dtL ^ i_polarity;
  assign o_duty_active = duty_q;

endmodule

// File: tb/tb_project_pwm_channel.sv
// Self-checking bench for project_pwm_channel: a behavioural master counter,
// a scoreboard fed by a reference model, and directed pulse-width checks.
module tb_project_pwm_channel;
  import project_pwm_channel_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_en;
  logic [1:0]  i_mode;
  logic        i_sync;
  logic [15:0] i_counter;
  logic [15:0] i_duty;
  logic [7:0]  i_deadtime;
  logic        i_polarity;
  logic        o_pwm_h;
  logic        o_pwm_l;
  logic [15:0] o_duty_active;

  project_pwm_channel dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_en          (i_en),
    .i_mode        (i_mode),
    .i_sync        (i_sync),
    .i_counter     (i_counter),
    .i_duty        (i_duty),
    .i_deadtime    (i_deadtime),
    .i_polarity    (i_polarity),
    .o_pwm_h       (o_pwm_h),
    .o_pwm_l       (o_pwm_l),
    .o_duty_active (o_duty_active)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        h;
    logic        l;
    logic [15:0] duty;
  } exp_t;

  exp_t        sbQueue[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  bit          checking = 1'b0;
  int          period = 15;
  bit          dirUp = 1'b1;
  int          hCount = 0;
  int          lCount = 0;

  logic [15:0] mDuty = '0;
  logic [7:0]  mDt = '0;
  bit          rawHist[16];
  bit          enHist[16];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: a side is driven once raw has held that level for
  // deadtime+1 consecutive samples while the channel stayed enabled.
  always @(posedge i_clk) begin : refModel
    exp_t e;
    bit   effEn, allOne, allZero, enOk, newRaw;
    int   d;
    effEn = i_en && !i_reset;
    d = int'(mDt);
    allOne = 1'b1;
    allZero = 1'b1;
    for (int k = 0; k <= d && k < 16; k++) begin
      if (rawHist[k]) allZero = 1'b0;
      else allOne = 1'b0;
    end
    enOk = effEn;
    for (int k = 0; k < d && k < 16; k++) begin
      if (!enHist[k]) enOk = 1'b0;
    end
    e.h = enOk && allOne;
    e.l = enOk && allZero;
    newRaw = effEn && (i_mode != 2'b00) && (i_counter < mDuty);
    for (int k = 15; k > 0; k--) begin
      rawHist[k] = rawHist[k-1];
      enHist[k]  = enHist[k-1];
    end
    rawHist[0] = newRaw;
    enHist[0]  = effEn;
    if (i_reset) begin
      mDuty = '0;
      mDt   = '0;
    end else if (i_sync || !i_en) begin
      mDuty = i_duty;
      mDt   = i_deadtime;
    end
    e.duty = mDuty;
    if (checking) sbQueue.push_back(e);
  end

  // Scoreboard: pop one expectation per edge and compare away from the edge.
  always @(posedge i_clk) begin : monitor
    exp_t e;
    if (checking) begin
      #1;
      if (sbQueue.size() == 0) begin
        checkOutput("sbEmpty", 32'd1, 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("pwmH", o_pwm_h, e.h ^ i_polarity);
        checkOutput("pwmL", o_pwm_l, e.l ^ i_polarity);
        checkOutput("dutyActive", o_duty_active, e.duty);
        checkOutput("noOverlap", (o_pwm_h ^ i_polarity) & (o_pwm_l ^ i_polarity), 32'd0);
      end
    end
  end

  // Behavioural period-counter master.
  task automatic advanceCounter();
    int c;
    c = int'(i_counter);
    case (i_mode)
      2'b01: begin
        c = (c >= period) ? 0 : c + 1;
        i_sync = (c == period);
      end
      2'b10: begin
        c = (c == 0) ? period : c - 1;
        i_sync = (c == 0);
      end
      2'b11: begin
        if (dirUp) begin
          if (c >= period) begin
            dirUp = 1'b0;
            c = c - 1;
          end else c = c + 1;
        end else begin
          if (c == 0) begin
            dirUp = 1'b1;
            c = 1;
          end else c = c - 1;
        end
        i_sync = (c == 0);
      end
      default: i_sync = 1'b0;
    endcase
    i_counter = c[15:0];
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge i_clk);
      advanceCounter();
      @(posedge i_clk);
      #2;
      if (o_pwm_h ^ i_polarity) hCount++;
      if (o_pwm_l ^ i_polarity) lCount++;
    end
  endtask

  task automatic setupChannel(input logic [1:0] mode, input logic [15:0] duty,
                              input logic [7:0] dt, input logic pol);
    i_en = 1'b0;
    i_mode = mode;
    i_duty = duty;
    i_deadtime = dt;
    i_polarity = pol;
    applyStimulus(3);
    i_counter = '0;
    i_sync = 1'b0;
    dirUp = 1'b1;
    i_en = 1'b1;
  endtask

  task automatic measure(input int n);
    hCount = 0;
    lCount = 0;
    applyStimulus(n);
  endtask

  initial begin
    i_reset = 1'b1;
    i_en = 1'b0;
    i_mode = MODE_UP;
    i_sync = 1'b0;
    i_counter = '0;
    i_duty = '0;
    i_deadtime = '0;
    i_polarity = 1'b0;
    checking = 1'b1;
    applyStimulus(2);
    checkOutput("rstH", o_pwm_h, 32'd0);
    checkOutput("rstL", o_pwm_l, 32'd0);
    checkOutput("rstDuty", o_duty_active, 32'd0);
    i_reset = 1'b0;

    setupChannel(MODE_UP, 16'd8, 8'd0, 1'b0);
    applyStimulus(32);
    measure(16);
    checkOutput("upDt0WidthH", hCount, 32'd8);
    checkOutput("upDt0WidthL", lCount, 32'd8);

    setupChannel(MODE_UP, 16'd8, 8'd3, 1'b0);
    applyStimulus(32);
    measure(16);
    checkOutput("upDt3WidthH", hCount, 32'd5);
    checkOutput("upDt3WidthL", lCount, 32'd5);

    setupChannel(MODE_UP, 16'd8, 8'd0, 1'b0);
    applyStimulus(20);
    for (int k = 0; k < 20 && i_counter != 16'd3; k++) applyStimulus(1);
    i_duty = 16'd4;
    applyStimulus(2);
    checkOutput("dutyHeld", o_duty_active, 32'd8);
    for (int k = 0; k < 20 && i_counter != 16'd15; k++) applyStimulus(1);
    checkOutput("dutyNew", o_duty_active, 32'd4);
    measure(16);
    checkOutput("dutyNewWidthH", hCount, 32'd4);

    setupChannel(MODE_UP, 16'd0, 8'd2, 1'b0);
    applyStimulus(20);
    measure(16);
    checkOutput("duty0H", hCount, 32'd0);
    checkOutput("duty0L", lCount, 32'd16);

    setupChannel(MODE_UP, 16'hFFFF, 8'd2, 1'b0);
    applyStimulus(20);
    measure(16);
    checkOutput("dutyMaxH", hCount, 32'd16);
    checkOutput("dutyMaxL", lCount, 32'd0);

    setupChannel(MODE_DOWN, 16'd5, 8'd1, 1'b0);
    applyStimulus(32);
    measure(16);
    checkOutput("downWidthH", hCount, 32'd4);
    checkOutput("downWidthL", lCount, 32'd10);

    setupChannel(MODE_UPDOWN, 16'd8, 8'd2, 1'b0);
    applyStimulus(60);
    measure(30);
    checkOutput("udWidthH", hCount, 32'd13);
    checkOutput("udWidthL", lCount, 32'd13);

    setupChannel(MODE_STOP, 16'd8, 8'd0, 1'b0);
    applyStimulus(5);
    measure(8);
    checkOutput("stopH", hCount, 32'd0);
    checkOutput("stopL", lCount, 32'd8);

    setupChannel(MODE_UP, 16'd8, 8'd2, 1'b0);
    applyStimulus(21);
    i_en = 1'b0;
    applyStimulus(3);
    i_en = 1'b1;
    applyStimulus(24);

    setupChannel(MODE_UP, 16'd8, 8'd3, 1'b1);
    applyStimulus(40);
    for (int k = 0; k < 20 && i_counter != 16'd15; k++) applyStimulus(1);
    applyStimulus(2);
    i_reset = 1'b1;
    applyStimulus(1);
    checkOutput("rstPolH", o_pwm_h, 32'd1);
    checkOutput("rstPolL", o_pwm_l, 32'd1);
    checkOutput("rstPolDuty", o_duty_active, 32'd0);
    applyStimulus(1);
    i_reset = 1'b0;
    measure(40);
    checkOutput("postRstSawH", (hCount > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
